aes_result_spi_tx: RTL and testbench
====================================

# aes_result_spi_tx

Downstream stage of the AES cipher. Captures the 128-bit ciphertext when the cipher flags it valid, then serialises it MSB-first onto an SPI MISO line under an active-low chip select, with the same framing as the input SPI receivers. It decouples cipher completion from host readout: a held result waits until the host asserts chip select, and an aborted frame restarts cleanly.

## Interface
- `DATA_W`, default 128: payload width in bits; must be a multiple of 8.
- `clk` input, 1 bit: system clock, also the SPI shift clock; all flops on the rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `data_in` input, DATA_W bits: ciphertext from the cipher.
- `data_valid` input, 1 bit: one-cycle pulse; `data_in` is valid this cycle.
- `cs` input, 1 bit: active-low chip select from the host.
- `miso` output, 1 bit: serial data out; 0 whenever `cs` is high.
- `ready` output, 1 bit: a result is held and not yet fully transmitted.
- `busy` output, 1 bit: a frame is shifting.
- `overrun` output, 1 bit: sticky flag; an untransmitted result was overwritten or dropped.

## Operation
- Registers:
  - `hold`: DATA_W-bit captured result.
  - `shreg`: shift register, sized to the frame.
  - `cnt`: bit counter, width clog2(frame length).
  - `crc`: 8-bit CRC register, present only with the macro.
- States:
  - IDLE: nothing held.
  - LOADED: result held, waiting for `cs` low.
  - SHIFT: frame in progress.
  - DONE: frame complete, waiting for `cs` to rise.
- IDLE or DONE, `data_valid`=1: `hold` and `shreg` load `data_in`, state becomes LOADED.
- LOADED, `data_valid`=1: `hold` and `shreg` are replaced by the new data and `overrun` is set. The newest result wins.
- SHIFT, `data_valid`=1: the data is dropped, `overrun` is set, and the frame continues unchanged.
- LOADED, `cs`=0 at an edge:
  - That edge is the host's sample of bit DATA_W-1. `shreg` shifts left by one, `cnt` becomes 1, state becomes SHIFT, `overrun` clears.
  - If `data_valid`=1 on the same edge, the capture takes priority: the new data loads, `overrun` sets, and the frame starts on the next edge.
- SHIFT, `cs`=0: one shift per edge. After the last frame bit is sampled, state becomes DONE and `ready` drops.
- SHIFT, `cs`=1 (abort): state returns to LOADED, `shreg` reloads from `hold`, and `cnt` clears. The next frame retransmits from the MSB.
- DONE, `cs`=1: state becomes IDLE. While `cs` stays low in DONE, `miso`=0.
- Outputs:
  - `miso` = `shreg` MSB when `cs`=0 and state is LOADED or SHIFT; 0 otherwise.
  - `ready` = 1 in LOADED or SHIFT.
  - `busy` = 1 in SHIFT.

## Timing
- Reset values: state IDLE, all registers 0, `miso`=0, `ready`=0, `busy`=0, `overrun`=0. Reset takes effect mid-frame immediately and the held result is lost.
- Capture latency is 1 cycle: `ready` rises on the edge after the `data_valid` edge.
- `miso` is combinational from `shreg` and `cs`. Bit k is stable for the whole cycle the host samples it.
- Frame length F is DATA_W bits (DATA_W+8 with the macro). `busy` is high for F-1 cycles. `ready` falls on the edge that samples the last bit.
- Minimum back-to-back result spacing with no overrun: F+2 cycles, including the `cs` deassert cycle.

## Configuration
- `AES_TX_CRC8_EN` defined:
  - Frame is DATA_W+8 bits: payload followed by CRC-8.
  - CRC uses poly 0x07, init 0x00, no reflection, no final XOR, computed over the payload MSB-first.
  - The CRC is computed serially as payload bits shift out and is appended MSB-first.
  - Abort and reload reset `crc` to 0x00.
- Not defined: frame is exactly DATA_W bits. No CRC logic and no `crc` register.

## Test plan
- **Basic readout.** Reset, pulse `data_valid` with 0x69c4e0d86a7b0430d8cdb78070b4c55a, wait 3 cycles, hold `cs` low for 128 cycles.
  - `miso` reproduces the value MSB-first.
  - `ready` goes 1→0 on the 128th edge; `busy` is high for cycles 2-128.
  - `miso`=0 afterwards.
- **Overwrite in LOADED.** Load 0x00..01, then load 0xFF..FF before `cs` falls.
  - `overrun`=1, and the frame shifts out all ones.
  - `overrun` clears on the first shift edge.
- **Drop during SHIFT.** Pulse `data_valid` at bit 40.
  - The frame completes with the original data and `overrun`=1.
  - Afterwards state is DONE and `ready`=0.
- **Abort and retransmit.** Raise `cs` after 50 bits, then lower it for 128 cycles.
  - The full value is retransmitted from bit 127 and `ready` stays 1 until the end.
- **Async reset mid-frame.** Assert `rst` at bit 60.
  - `miso`, `ready` and `busy` go to 0 without waiting for a clock edge.
  - After release, `cs` low produces only zeros.
- **CRC (`AES_TX_CRC8_EN`).** Basic readout with 136 cycles.
  - The last 8 bits equal the CRC-8 (poly 0x07) of the payload, computed by the bench model.
  - An all-zero payload yields CRC 0x00.

Source files
------------

// File: rtl/aes_result_spi_tx.sv
// Captures the cipher result and serialises it MSB-first on MISO under active-low cs.
// Define AES_TX_CRC8_EN to append a serially computed CRC-8 (poly 0x07) to each frame.
module aes_result_spi_tx #(
  parameter int unsigned DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              cs,
  output logic              miso,
  output logic              ready,
  output logic              busy,
  output logic              overrun
);

`ifdef AES_TX_CRC8_EN
  localparam int unsigned F = DATA_W + 8;
`else
  localparam int unsigned F = DATA_W;
`endif
  localparam int unsigned CW = $clog2(F);
  localparam logic [CW-1:0] CNT_LAST = CW'(F - 1);

  typedef enum logic [1:0] {IDLE, LOADED, SHIFT, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] hold;
  logic [F-1:0]      shreg;
  logic [F-1:0]      shreg_adv;
  logic [CW-1:0]     cnt;
  logic              shift_en;

  function automatic logic [F-1:0] load_frame(input logic [DATA_W-1:0] d);
`ifdef AES_TX_CRC8_EN
    return {d, 8'h00};
`else
    return d;
`endif
  endfunction

  // True on every edge at which the host samples a frame bit.
  assign shift_en = !cs && ((state == LOADED && !data_valid) || state == SHIFT);

`ifdef AES_TX_CRC8_EN
  localparam logic [CW-1:0] CNT_PAY_LAST = CW'(DATA_W - 1);

  logic [7:0] crc;
  logic [7:0] crc_nx;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  // Once the last payload bit is sampled, the CRC replaces the exhausted tail.
  always_comb begin
    crc_nx    = (cnt <= CNT_PAY_LAST) ? crc8_step(crc, shreg[F-1]) : crc;
    shreg_adv = {shreg[F-2:0], 1'b0};
    if (state == SHIFT && cnt == CNT_PAY_LAST)
      shreg_adv = {crc_nx, {(F-8){1'b0}}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) crc <= 8'h00;
    else      crc <= shift_en ? crc_nx : 8'h00;
  end
`else
  assign shreg_adv = {shreg[F-2:0], 1'b0};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      hold    <= '0;
      shreg   <= '0;
      cnt     <= '0;
      ready   <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (data_valid) begin
            hold  <= data_in;
            shreg <= load_frame(data_in);
            cnt   <= '0;
            state <= LOADED;
            ready <= 1'b1;
          end else if (state == DONE && cs) begin
            state <= IDLE;
          end
        end
        LOADED: begin
          if (data_valid) begin
            hold    <= data_in;
            shreg   <= load_frame(data_in);
            overrun <= 1'b1;
          end else if (!cs) begin
            shreg   <= shreg_adv;
            cnt     <= CW'(1);
            state   <= SHIFT;
            busy    <= 1'b1;
            overrun <= 1'b0;
          end
        end
        SHIFT: begin
          if (data_valid) overrun <= 1'b1;
          if (cs) begin
            shreg <= load_frame(hold);
            cnt   <= '0;
            state <= LOADED;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            shreg <= shreg_adv;
            cnt   <= '0;
            state <= DONE;
            ready <= 1'b0;
            busy  <= 1'b0;
          end else begin
            shreg <= shreg_adv;
            cnt   <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ready is high exactly in LOADED and SHIFT, so it gates MISO directly.
  assign miso = !cs && ready && shreg[F-1];

endmodule

// File: tb/tb_aes_result_spi_tx.sv
// Directed and randomized checks of aes_result_spi_tx against a frame-level model.
module tb_aes_result_spi_tx;
  localparam int unsigned DW = 128;
`ifdef AES_TX_CRC8_EN
  localparam int unsigned FR = DW + 8;
`else
  localparam int unsigned FR = DW;
`endif

  logic          clk = 1'b0;
  logic          rst, data_valid, cs;
  logic [DW-1:0] data_in;
  logic          miso, ready, busy, overrun;
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;

  aes_result_spi_tx #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .cs(cs), .miso(miso), .ready(ready), .busy(busy), .overrun(overrun)
  );

  function automatic logic [7:0] crc8_model(input logic [DW-1:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int unsigned k = 0; k < DW / 8; k++) begin
      c ^= d[DW-1-8*k -: 8];
      for (int j = 0; j < 8; j++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic [FR-1:0] exp_frame(input logic [DW-1:0] d);
`ifdef AES_TX_CRC8_EN
    return {d, crc8_model(d)};
`else
    return d;
`endif
  endfunction

  function automatic logic [DW-1:0] rnd_payload();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [DW-1:0] d);
    data_in    = d;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  // Holds cs low for n cycles collecting MISO bits; optionally pulses data_valid at bit inj.
  task automatic frame(input int n, input int inj, input logic [DW-1:0] inj_d,
                       output logic [FR-1:0] got, output int busy_n,
                       output int ready_n, output logic ov1);
    got = '0; busy_n = 0; ready_n = 0; ov1 = 1'bx;
    cs = 1'b0;
    #1;
    for (int i = 0; i < n; i++) begin
      got[FR-1-i] = miso;
      data_valid = (i == inj);
      if (i == inj) data_in = inj_d;
      tick();
      busy_n  += int'(busy);
      ready_n += int'(ready);
      if (i == 0) ov1 = overrun;
    end
    data_valid = 1'b0;
  endtask

  initial begin
    logic [FR-1:0] got;
    logic [DW-1:0] da, db;
    int            bn, rn;
    logic          ov;

    rst = 1'b0; cs = 1'b1; data_valid = 1'b0; data_in = '0;
    #3;
    chk("rst_miso", miso, 0);
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    @(posedge clk); #2;
    rst = 1'b1;
    tick();

    // Basic readout of the reference vector
    da = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    load(da);
    chk("cap_ready", ready, 1);
    chk("cap_busy", busy, 0);
    chk("cap_overrun", overrun, 0);
    tick(); tick();
    frame(FR, -1, '0, got, bn, rn, ov);
    chk("basic_frame", got, exp_frame(da));
    chk("basic_busy_cycles", bn, FR - 1);
    chk("basic_ready_cycles", rn, FR - 1);
    chk("basic_ready_end", ready, 0);
    chk("basic_miso_done", miso, 0);
    cs = 1'b1; tick();
    chk("basic_idle_ready", ready, 0);

    // Random payloads, first one all-zero
    for (int t = 0; t < 5; t++) begin
      da = (t == 0) ? '0 : rnd_payload();
      load(da);
      repeat ($urandom_range(0, 3)) tick();
      frame(FR, -1, '0, got, bn, rn, ov);
      chk("rand_frame", got, exp_frame(da));
      chk("rand_ready_cycles", rn, FR - 1);
      cs = 1'b1; tick();
    end

    // Overwrite while LOADED: newest result wins
    load(128'h1);
    tick();
    load({DW{1'b1}});
    chk("ovw_overrun", overrun, 1);
    chk("ovw_ready", ready, 1);
    frame(FR, -1, '0, got, bn, rn, ov);
    chk("ovw_frame", got, exp_frame({DW{1'b1}}));
    chk("ovw_overrun_clear", ov, 0);
    cs = 1'b1; tick();

    // Capture beats frame start on the same edge
    da = rnd_payload(); db = rnd_payload();
    load(da);
    cs = 1'b0; data_in = db; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    chk("prio_busy", busy, 0);
    chk("prio_overrun", overrun, 1);
    frame(FR, -1, '0, got, bn, rn, ov);
    chk("prio_frame", got, exp_frame(db));
    cs = 1'b1; tick();

    // Result arriving mid-frame is dropped
    da = rnd_payload(); db = rnd_payload();
    load(da);
    frame(FR, 40, db, got, bn, rn, ov);
    chk("drop_frame", got, exp_frame(da));
    chk("drop_overrun", overrun, 1);
    chk("drop_ready", ready, 0);
    chk("drop_busy", busy, 0);
    cs = 1'b1; tick();

    // Abort after 50 bits, then full retransmission
    da = rnd_payload();
    load(da);
    frame(50, -1, '0, got, bn, rn, ov);
    cs = 1'b1; tick();
    chk("abort_ready", ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_miso_cs_high", miso, 0);
    tick();
    frame(FR, -1, '0, got, bn, rn, ov);
    chk("abort_frame", got, exp_frame(da));
    chk("abort_ready_cycles", rn, FR - 1);
    cs = 1'b1; tick();

    // Asynchronous reset mid-frame
    da = {DW{1'b1}};
    load(da);
    frame(60, -1, '0, got, bn, rn, ov);
    rst = 1'b0;
    #1;
    chk("arst_miso", miso, 0);
    chk("arst_ready", ready, 0);
    chk("arst_busy", busy, 0);
    tick();
    rst = 1'b1;
    tick();
    frame(40, -1, '0, got, bn, rn, ov);
    chk("arst_zeros", got, 0);
    chk("arst_no_ready", rn, 0);
    cs = 1'b1; tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
